pc_update_unit: RTL and testbench

Multi-cycle PC redirect engine that resolves the control-flow requests the hazard detector stalls on. It captures a call/ret/branch/jreg request while `PC_hazard` is high, computes the new PC, and drives a return-address stack. It then pulses `PC_update` to release the stall and load the fetch PC. It sits between decode (request source) and the fetch PC register.

---
 rtl/pc_update_pkg.sv | 37 +++
 rtl/pc_update_unit_if.sv | 42 ++++
 rtl/pc_update_unit_ras_stack.sv | 58 +++++
 rtl/pc_update_unit.sv | 141 ++++++++++++++
 tb/tb_pc_update_unit.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/pc_update_pkg.sv
// pc_update_pkg
// Shared types and defaults for the PC redirect engine.
//   op_t    : decoded control-flow operation captured from decode
//   state_t : redirect FSM states
//   decode_op() : collapses the raw op lines into a single op, applying
//                 the priority ret > call > jreg > branch
package pc_update_pkg;

  localparam int DEFAULT_PC_WIDTH    = 16;
  localparam int DEFAULT_STACK_DEPTH = 16;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_BR   = 3'd1,
    OP_JREG = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic op_t decode_op(input logic call, input logic ret,
                                    input logic jreg, input logic branch);
    op_t op;
    if (ret)         op = OP_RET;
    else if (call)   op = OP_CALL;
    else if (jreg)   op = OP_JREG;
    else if (branch) op = OP_BR;
    else             op = OP_NONE;
    return op;
  endfunction

endpackage

// File: rtl/pc_update_unit_if.sv
// pc_update_if
// Bundles the request lines coming from decode/hazard logic and the
// redirect results going to the fetch PC register.
//   master : request source (decode side) - drives PC_hazard, op lines,
//            branch_taken and the candidate addresses; observes results
//   slave  : pc_update_unit - consumes requests, drives PC_update, PC_next,
//            pop, stack_err, stack_count
interface pc_update_if
  import pc_update_pkg::*;
#(
  parameter int PC_WIDTH    = DEFAULT_PC_WIDTH,
  parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) ();

  logic                          PC_hazard;
  logic                          call;
  logic                          ret;
  logic                          branch;
  logic                          jreg;
  logic                          branch_taken;
  logic [PC_WIDTH-1:0]           PC_plus1;
  logic [PC_WIDTH-1:0]           branch_target;
  logic [PC_WIDTH-1:0]           jreg_target;
  logic                          PC_update;
  logic [PC_WIDTH-1:0]           PC_next;
  logic                          pop;
  logic                          stack_err;
  logic [$clog2(STACK_DEPTH):0]  stack_count;

  modport master (
    output PC_hazard, call, ret, branch, jreg, branch_taken,
           PC_plus1, branch_target, jreg_target,
    input  PC_update, PC_next, pop, stack_err, stack_count
  );

  modport slave (
    input  PC_hazard, call, ret, branch, jreg, branch_taken,
           PC_plus1, branch_target, jreg_target,
    output PC_update, PC_next, pop, stack_err, stack_count
  );

endinterface

// File: rtl/pc_update_unit_ras_stack.sv
// ras_stack
// Register-array LIFO used as the return-address stack.
//   clk, rst : clock and synchronous active-high reset (clears count only)
//   push     : write din on top of stack (ignored when full)
//   pop      : discard top of stack (ignored when empty)
//   din      : value to push
//   dout     : current top of stack, combinational; 0 when empty
//   count    : occupancy, 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
module ras_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          din,
  output logic [WIDTH-1:0]          dout,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    top_idx;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // With DEPTH a power of two, a full stack has zero low bits, so the
  // decrement wraps to DEPTH-1 and still addresses the top entry.
  assign top_idx = count[AW-1:0] - 1'b1;
  assign dout    = empty ? '0 : mem[top_idx];

  // Contents are not reset; a write is simply suppressed in a reset cycle.
  always_ff @(posedge clk) begin
    if (!rst && push && !full) begin
      mem[count[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + 1'b1;
    end else if (pop && !empty) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_update_unit.sv
// pc_update_unit
// Multi-cycle PC redirect engine. Captures a call/ret/branch/jreg request
// while the hazard detector stalls, resolves the new fetch address, maintains
// the return-address stack, and pulses PC_update to release the stall.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : pc_update_if slave
//     in : PC_hazard, call, ret, branch, jreg, branch_taken,
//          PC_plus1, branch_target, jreg_target
//     out: PC_update (1-cycle pulse), PC_next (held), pop (EXEC of ret),
//          stack_err (sticky), stack_count
module pc_update_unit
  import pc_update_pkg::*;
#(
  parameter int PC_WIDTH    = DEFAULT_PC_WIDTH,
  parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
  input logic       clk,
  input logic       rst,
  pc_update_if.slave bus
);

  localparam int CW = $clog2(STACK_DEPTH) + 1;

  state_t              state;
  op_t                 op_q;
  op_t                 req_op;
  logic                taken_q;
  logic [PC_WIDTH-1:0] plus1_q;
  logic [PC_WIDTH-1:0] btgt_q;
  logic [PC_WIDTH-1:0] jtgt_q;

  logic                push_q;
  logic                pop_q;
  logic                update_q;
  logic [PC_WIDTH-1:0] next_q;
  logic                err_q;

  logic [PC_WIDTH-1:0] stack_dout;
  logic [CW-1:0]       stack_count;
  logic                stack_full;
  logic                stack_empty;

  logic [PC_WIDTH-1:0] exec_target;
  logic                exec_err;

  assign req_op = decode_op(bus.call, bus.ret, bus.jreg, bus.branch);

  // push_q/pop_q are only high during EXEC, so the stack commits at the end
  // of EXEC. A reset on that edge clears the count, so nothing is kept.
  ras_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .pop   (pop_q),
    .din   (plus1_q),
    .dout  (stack_dout),
    .count (stack_count),
    .full  (stack_full),
    .empty (stack_empty)
  );

  // Target mux for the latched op; the stack top is read before the
  // end-of-EXEC pop, so a ret sees the entry it is about to remove.
  always_comb begin
    exec_target = '0;
    exec_err    = 1'b0;
    unique case (op_q)
      OP_CALL: begin
        exec_target = btgt_q;
        exec_err    = stack_full;
      end
      OP_RET: begin
        exec_target = stack_empty ? '0 : stack_dout;
        exec_err    = stack_empty;
      end
      OP_JREG: exec_target = jtgt_q;
      OP_BR:   exec_target = taken_q ? btgt_q : plus1_q;
      default: exec_target = '0;
    endcase
  end

  // Redirect FSM: IDLE captures a stalled request, EXEC resolves it and
  // drives the stack, DONE presents the pulse. Hazard is ignored outside IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= OP_NONE;
      taken_q  <= 1'b0;
      plus1_q  <= '0;
      btgt_q   <= '0;
      jtgt_q   <= '0;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      update_q <= 1'b0;
      next_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          update_q <= 1'b0;
          if (bus.PC_hazard && (req_op != OP_NONE)) begin
            op_q    <= req_op;
            taken_q <= bus.branch_taken;
            plus1_q <= bus.PC_plus1;
            btgt_q  <= bus.branch_target;
            jtgt_q  <= bus.jreg_target;
            push_q  <= (req_op == OP_CALL);
            pop_q   <= (req_op == OP_RET);
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          next_q   <= exec_target;
          update_q <= 1'b1;
          push_q   <= 1'b0;
          pop_q    <= 1'b0;
          if (exec_err) begin
            err_q <= 1'b1;
          end
          state <= ST_DONE;
        end
        ST_DONE: begin
          update_q <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.PC_update   = update_q;
  assign bus.PC_next     = next_q;
  assign bus.pop         = pop_q;
  assign bus.stack_err   = err_q;
  assign bus.stack_count = stack_count;

endmodule

// File: tb/tb_pc_update_unit.sv
// tb_pc_update_unit
// Directed self-checking bench for pc_update_unit (PC_WIDTH=16,
// STACK_DEPTH=16). Expected values are hand-computed constants.
module tb_pc_update_unit;

  logic clk;
  logic rst;

  int total = 0;
  int bad   = 0;

  // Values captured by applyStimulus across one request
  logic        popSeen;
  logic [4:0]  countExec;
  logic        updSeen;
  logic [15:0] nextSeen;
  logic [4:0]  countDone;
  logic        errDone;
  logic        updAfter;

  pc_update_if #(.PC_WIDTH(16), .STACK_DEPTH(16)) bus ();

  pc_update_unit #(.PC_WIDTH(16), .STACK_DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    bus.PC_hazard     = 1'b0;
    bus.call          = 1'b0;
    bus.ret           = 1'b0;
    bus.branch        = 1'b0;
    bus.jreg          = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.PC_plus1      = 16'h0;
    bus.branch_target = 16'h0;
    bus.jreg_target   = 16'h0;
  endtask

  // Called in an IDLE cycle (#1 after an edge). Drives a stalled request,
  // follows it through EXEC and DONE, and returns in the following IDLE cycle.
  task automatic applyStimulus(input logic c, input logic r, input logic j,
                               input logic b, input logic tk,
                               input logic [15:0] plus1,
                               input logic [15:0] btgt,
                               input logic [15:0] jtgt);
    bus.PC_hazard     = 1'b1;
    bus.call          = c;
    bus.ret           = r;
    bus.jreg          = j;
    bus.branch        = b;
    bus.branch_taken  = tk;
    bus.PC_plus1      = plus1;
    bus.branch_target = btgt;
    bus.jreg_target   = jtgt;
    @(posedge clk); #1;
    clearInputs();
    popSeen   = bus.pop;
    countExec = bus.stack_count;
    @(posedge clk); #1;
    updSeen   = bus.PC_update;
    nextSeen  = bus.PC_next;
    countDone = bus.stack_count;
    errDone   = bus.stack_err;
    @(posedge clk); #1;
    updAfter  = bus.PC_update;
  endtask

  task automatic doReset();
    rst = 1'b1;
    clearInputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clearInputs();
    doReset();

    // Reset state
    checkOutput("rst_update", bus.PC_update, 0);
    checkOutput("rst_next", bus.PC_next, 0);
    checkOutput("rst_pop", bus.pop, 0);
    checkOutput("rst_err", bus.stack_err, 0);
    checkOutput("rst_count", bus.stack_count, 0);

    // Taken branch
    applyStimulus(0, 0, 0, 1, 1, 16'h0010, 16'h0040, 16'h0000);
    checkOutput("br_t_update", updSeen, 1);
    checkOutput("br_t_next", nextSeen, 16'h0040);
    checkOutput("br_t_pulse_end", updAfter, 0);
    checkOutput("br_t_pop", popSeen, 0);

    // Not-taken branch, issued back-to-back
    applyStimulus(0, 0, 0, 1, 0, 16'h0011, 16'h0040, 16'h0000);
    checkOutput("br_nt_update", updSeen, 1);
    checkOutput("br_nt_next", nextSeen, 16'h0011);

    // jreg
    applyStimulus(0, 0, 1, 0, 0, 16'h0020, 16'h0030, 16'h1234);
    checkOutput("jreg_next", nextSeen, 16'h1234);

    // call then ret
    applyStimulus(1, 0, 0, 0, 0, 16'h0105, 16'h0200, 16'h0000);
    checkOutput("call_next", nextSeen, 16'h0200);
    checkOutput("call_count_exec", countExec, 0);
    checkOutput("call_count_done", countDone, 1);
    applyStimulus(0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
    checkOutput("ret_pop", popSeen, 1);
    checkOutput("ret_next", nextSeen, 16'h0105);
    checkOutput("ret_count", countDone, 0);
    checkOutput("ret_err", errDone, 0);
    checkOutput("ret_pop_end", bus.pop, 0);

    // Hazard without op, then op without hazard: no update
    bus.PC_hazard = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.PC_hazard = 1'b0;
    bus.branch = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_target = 16'h0999;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("noreq_update", bus.PC_update, 0);
    @(posedge clk); #1;
    checkOutput("noreq_update2", bus.PC_update, 0);
    checkOutput("noreq_next", bus.PC_next, 16'h0105);
    clearInputs();

    // 17 calls: count saturates at 16, error on the 17th
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'h0000);
      checkOutput($sformatf("ovf_next_%0d", i), nextSeen, 16'h2000 + i);
      checkOutput($sformatf("ovf_count_%0d", i), countDone, (i < 16) ? i + 1 : 16);
      checkOutput($sformatf("ovf_err_%0d", i), errDone, (i == 16) ? 1 : 0);
    end

    // 16 rets in LIFO order; the dropped 17th push never appears
    for (int j = 0; j < 16; j++) begin
      applyStimulus(0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
      checkOutput($sformatf("lifo_next_%0d", j), nextSeen, 16'h1000 + (15 - j));
      checkOutput($sformatf("lifo_count_%0d", j), countDone, 15 - j);
    end

    // Underflow after a reset clears the sticky flag
    doReset();
    checkOutput("rst2_err", bus.stack_err, 0);
    applyStimulus(0, 1, 0, 0, 0, 16'h0abc, 16'h0def, 16'h0000);
    checkOutput("udf_next", nextSeen, 16'h0000);
    checkOutput("udf_pop", popSeen, 1);
    checkOutput("udf_err", errDone, 1);
    checkOutput("udf_count", countDone, 0);
    applyStimulus(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h4321);
    checkOutput("sticky_next", nextSeen, 16'h4321);
    checkOutput("sticky_err", errDone, 1);

    // call and ret together: ret wins
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 16'h0033, 16'h0300, 16'h0000);
    checkOutput("prio_setup_count", countDone, 1);
    applyStimulus(1, 1, 0, 0, 0, 16'h0077, 16'h0500, 16'h0000);
    checkOutput("prio_next", nextSeen, 16'h0033);
    checkOutput("prio_count", countDone, 0);
    checkOutput("prio_err", errDone, 0);

    // Reset during EXEC of a call aborts it
    bus.PC_hazard     = 1'b1;
    bus.call          = 1'b1;
    bus.PC_plus1      = 16'h0abc;
    bus.branch_target = 16'h0def;
    @(posedge clk); #1;
    clearInputs();
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_update", bus.PC_update, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_update2", bus.PC_update, 0);
    checkOutput("abort_count", bus.stack_count, 0);
    checkOutput("abort_next", bus.PC_next, 0);
    applyStimulus(0, 0, 0, 1, 1, 16'h0056, 16'h0055, 16'h0000);
    checkOutput("after_abort_next", nextSeen, 16'h0055);
    checkOutput("after_abort_update", updSeen, 1);
    checkOutput("after_abort_count", countDone, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
